compass_seq_matcher: RTL and testbench

//  Parametrised, run-time programmable direction-sequence detector.

---
 rtl/compass_seq_matcher.sv | 137 +++++++++++++
 tb/tb_compass_seq_matcher.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/compass_seq_matcher.sv
// Programmable direction-sequence detector: compares the newest symbols against a
// run-time pattern, pulses on a match, counts matches and drops stale history on idle.
//
// state     | meaning
// S_EMPTY   | no history held (fill = 0)
// S_FILLING | some history, not yet enough to complete the pattern
// S_ARMED   | fill >= len-1, the next valid symbol can complete a match
module compass_seq_matcher #(
   parameter int DIR_W          = 2,
   parameter int MAX_LEN        = 8,
   parameter int CNT_W          = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic [DIR_W-1:0]             direction_i,
   input  logic                         valid_i,
   input  logic                         cfg_we_i,
   input  logic [$clog2(MAX_LEN)-1:0]   cfg_addr_i,
   input  logic [DIR_W-1:0]             cfg_dir_i,
   input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len_i,
   input  logic                         overlap_i,
   input  logic                         clear_i,
   output logic                         sequence_detected_o,
   output logic [CNT_W-1:0]             match_count_o,
   output logic                         busy_o
);

   localparam int ADDR_W = $clog2(MAX_LEN);
   localparam int LEN_W  = $clog2(MAX_LEN+1);
   localparam int HIST_N = MAX_LEN - 1;
   localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES+1) : 1;

   localparam logic [LEN_W-1:0]  FILL_MAX = LEN_W'(MAX_LEN-1);
   localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(MAX_LEN);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
   localparam logic [IDLE_W-1:0] IDLE_TC  = IDLE_W'(TIMEOUT_CYCLES-1);

   localparam logic [1:0] S_EMPTY   = 2'd0;
   localparam logic [1:0] S_FILLING = 2'd1;
   localparam logic [1:0] S_ARMED   = 2'd2;

   logic [DIR_W-1:0]  r_pat  [MAX_LEN];
   logic [DIR_W-1:0]  r_hist [HIST_N];
   logic [LEN_W-1:0]  r_len;
   logic [LEN_W-1:0]  r_fill;
   logic [IDLE_W-1:0] r_idle;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_det;
   logic              r_busy;

   logic [1:0]        w_state;
   logic              w_match;
   logic              w_timeout;
   logic              w_shift;
   logic [LEN_W-1:0]  w_fill_nxt;
   logic [LEN_W-1:0]  w_len_clamp;

   assign w_len_clamp = (cfg_len_i > LEN_MAX) ? LEN_MAX : cfg_len_i;

   always_comb begin
      w_state = S_FILLING;
      if (r_len != '0 && (r_fill + LEN_W'(1)) >= r_len)
         w_state = S_ARMED;
      else if (r_fill == '0)
         w_state = S_EMPTY;
   end

   // hist[j] (j-th newest) must equal pat[len-2-j]; the incoming symbol closes pat[len-1]
   always_comb begin
      w_match = valid_i && (w_state == S_ARMED) &&
                (direction_i == r_pat[ADDR_W'(r_len - LEN_W'(1))]);
      for (int j = 0; j < HIST_N; j++) begin
         if (LEN_W'(j+2) <= r_len && r_hist[j] != r_pat[ADDR_W'(r_len - LEN_W'(j+2))])
            w_match = 1'b0;
      end
   end

   assign w_timeout = (TIMEOUT_CYCLES != 0) && !valid_i && (r_fill != '0) && (r_idle == IDLE_TC);
   assign w_shift   = !cfg_we_i && !clear_i && valid_i && !(w_match && !overlap_i);

   always_comb begin
      w_fill_nxt = r_fill;
      if (cfg_we_i || clear_i || w_timeout)
         w_fill_nxt = '0;
      else if (valid_i) begin
         if (w_match && !overlap_i)
            w_fill_nxt = '0;
         else if (r_fill < FILL_MAX)
            w_fill_nxt = r_fill + LEN_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < MAX_LEN; i++) r_pat[i] <= '0;
         for (int i = 0; i < HIST_N; i++) r_hist[i] <= '0;
         r_len  <= '0;
         r_fill <= '0;
         r_idle <= '0;
         r_cnt  <= '0;
         r_det  <= 1'b0;
         r_busy <= 1'b0;
      end else begin
         r_fill <= w_fill_nxt;
         r_busy <= (w_fill_nxt != '0);
         r_det  <= !cfg_we_i && !clear_i && w_match;

         if (cfg_we_i) begin
            r_pat[cfg_addr_i] <= cfg_dir_i;
            r_len             <= w_len_clamp;
         end

         if (cfg_we_i || clear_i || w_timeout || valid_i)
            r_idle <= '0;
         else if (r_fill != '0 && TIMEOUT_CYCLES != 0)
            r_idle <= r_idle + IDLE_W'(1);

         if (!cfg_we_i) begin
            if (clear_i)
               r_cnt <= '0;
            else if (w_match && r_cnt != CNT_MAX)
               r_cnt <= r_cnt + CNT_W'(1);
         end

         if (w_shift) begin
            r_hist[0] <= direction_i;
            for (int i = 1; i < HIST_N; i++) r_hist[i] <= r_hist[i-1];
         end
      end
   end

   assign sequence_detected_o = r_det;
   assign match_count_o       = r_cnt;
   assign busy_o              = r_busy;

endmodule

// File: tb/tb_compass_seq_matcher.sv
// Directed bench for compass_seq_matcher: hand-computed pulses, counts and busy flags
// for overlap, non-overlap, timeout, saturation, reset, config collision and length edges.
module tb_compass_seq_matcher;

   logic       clk_i = 1'b0;
   logic       reset_i;
   logic [1:0] direction_i;
   logic       valid_i;
   logic       cfg_we_i;
   logic [2:0] cfg_addr_i;
   logic [1:0] cfg_dir_i;
   logic [3:0] cfg_len_i;
   logic       overlap_i;
   logic       clear_i;
   logic       sequence_detected_o;
   logic [1:0] match_count_o;
   logic       busy_o;

   int n_tests = 0;
   int n_fail  = 0;

   compass_seq_matcher #(.DIR_W(2), .MAX_LEN(8), .CNT_W(2), .TIMEOUT_CYCLES(16)) u_dut (
      .clk_i               (clk_i),
      .reset_i             (reset_i),
      .direction_i         (direction_i),
      .valid_i             (valid_i),
      .cfg_we_i            (cfg_we_i),
      .cfg_addr_i          (cfg_addr_i),
      .cfg_dir_i           (cfg_dir_i),
      .cfg_len_i           (cfg_len_i),
      .overlap_i           (overlap_i),
      .clear_i             (clear_i),
      .sequence_detected_o (sequence_detected_o),
      .match_count_o       (match_count_o),
      .busy_o              (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic sym(input logic [1:0] d);
      valid_i     = 1'b1;
      direction_i = d;
      tick();
      valid_i     = 1'b0;
   endtask

   task automatic idle();
      tick();
   endtask

   task automatic cfg(input logic [2:0] a, input logic [1:0] d, input logic [3:0] len);
      cfg_we_i   = 1'b1;
      cfg_addr_i = a;
      cfg_dir_i  = d;
      cfg_len_i  = len;
      tick();
      cfg_we_i   = 1'b0;
   endtask

   task automatic clr();
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
   endtask

   task automatic prog3(input logic [1:0] d0, input logic [1:0] d1, input logic [1:0] d2);
      cfg(3'd0, d0, 4'd3);
      cfg(3'd1, d1, 4'd3);
      cfg(3'd2, d2, 4'd3);
   endtask

   logic [1:0] stream5 [5] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
   logic       exp_ov  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
   logic       exp_nov [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

   initial begin
      reset_i = 1'b1; direction_i = '0; valid_i = 1'b0; cfg_we_i = 1'b0;
      cfg_addr_i = '0; cfg_dir_i = '0; cfg_len_i = '0; overlap_i = 1'b1; clear_i = 1'b0;
      #12;
      check("rst_det",  sequence_detected_o, 0);
      check("rst_cnt",  match_count_o, 0);
      check("rst_busy", busy_o, 0);
      @(negedge clk_i);
      reset_i = 1'b0;
      tick();

      // overlapping
      overlap_i = 1'b1;
      prog3(2'b10, 2'b01, 2'b10);
      for (int i = 0; i < 5; i++) begin
         sym(stream5[i]);
         check($sformatf("ov_det%0d", i), sequence_detected_o, exp_ov[i]);
      end
      check("ov_cnt", match_count_o, 2);

      // non-overlapping
      clr();
      check("clr_cnt",  match_count_o, 0);
      check("clr_busy", busy_o, 0);
      overlap_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         sym(stream5[i]);
         check($sformatf("nov_det%0d", i), sequence_detected_o, exp_nov[i]);
      end
      check("nov_cnt", match_count_o, 1);

      // idle timeout
      clr();
      overlap_i = 1'b1;
      sym(2'b10);
      sym(2'b01);
      check("to_busy0", busy_o, 1);
      repeat (15) idle();
      check("to_busy15", busy_o, 1);
      idle();
      check("to_busy16", busy_o, 0);
      sym(2'b10);
      check("to_det", sequence_detected_o, 0);
      check("to_cnt", match_count_o, 0);

      // counter saturation, matches at symbols 3,5,7,9,11
      clr();
      for (int i = 0; i < 11; i++) begin
         sym((i % 2 == 0) ? 2'b10 : 2'b01);
         if (i == 4)  check("sat_cnt2", match_count_o, 2);
         if (i == 6)  check("sat_cnt3", match_count_o, 3);
         if (i == 10) check("sat_det", sequence_detected_o, 1);
      end
      check("sat_cnt", match_count_o, 3);
      clr();
      check("sat_clr_cnt",  match_count_o, 0);
      check("sat_clr_busy", busy_o, 0);

      // asynchronous reset with a pulse in flight
      sym(2'b10);
      sym(2'b01);
      sym(2'b10);
      check("ar_det_pre", sequence_detected_o, 1);
      check("ar_cnt_pre", match_count_o, 1);
      #3 reset_i = 1'b1;
      #1;
      check("ar_det",  sequence_detected_o, 0);
      check("ar_cnt",  match_count_o, 0);
      check("ar_busy", busy_o, 0);
      #1 reset_i = 1'b0;
      sym(2'b10);
      check("ar_post_det",  sequence_detected_o, 0);
      check("ar_post_busy", busy_o, 1);

      // config write colliding with a completing symbol
      prog3(2'b10, 2'b01, 2'b10);
      sym(2'b10);
      sym(2'b01);
      valid_i = 1'b1; direction_i = 2'b10;
      cfg_we_i = 1'b1; cfg_addr_i = 3'd2; cfg_dir_i = 2'b11; cfg_len_i = 4'd3;
      tick();
      valid_i = 1'b0; cfg_we_i = 1'b0;
      check("cw_det",  sequence_detected_o, 0);
      check("cw_busy", busy_o, 0);
      check("cw_cnt",  match_count_o, 0);
      sym(2'b10);
      sym(2'b01);
      sym(2'b11);
      check("cw_new_det", sequence_detected_o, 1);
      check("cw_new_cnt", match_count_o, 1);

      // single-symbol pattern
      cfg(3'd0, 2'b11, 4'd1);
      sym(2'b11);
      check("l1_det_a", sequence_detected_o, 1);
      sym(2'b00);
      check("l1_det_b", sequence_detected_o, 0);
      sym(2'b11);
      check("l1_det_c", sequence_detected_o, 1);
      check("l1_cnt",   match_count_o, 3);

      // over-long length clamps to MAX_LEN
      clr();
      for (int a = 0; a < 8; a++) cfg(3'(a), 2'b01, 4'd15);
      for (int i = 0; i < 8; i++) begin
         sym(2'b01);
         check($sformatf("cl_det%0d", i), sequence_detected_o, (i == 7) ? 1 : 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
